// File: rtl/onehot_sequencer_if.sv
// Command/status bundle for onehot_sequencer; the err signal only exists
// when ONEHOT_SEQ_ERR_EN is defined.
interface onehot_sequencer_if #(
  parameter int N    = 4,
  parameter int OUTS = 16
);
  logic            clr;
  logic            ld;
  logic [N-1:0]    w;
  logic            scan;
  logic            dir;
  logic            en;
  logic [OUTS-1:0] y;
  logic [N-1:0]    idx;
  logic            valid;
  logic            wrap;
`ifdef ONEHOT_SEQ_ERR_EN
  logic            err;

  modport master (output clr, ld, w, scan, dir, en,
                  input  y, idx, valid, wrap, err);
  modport slave  (input  clr, ld, w, scan, dir, en,
                  output y, idx, valid, wrap, err);
`else
  modport master (output clr, ld, w, scan, dir, en,
                  input  y, idx, valid, wrap);
  modport slave  (input  clr, ld, w, scan, dir, en,
                  output y, idx, valid, wrap);
`endif
endinterface

// File: rtl/onehot_sequencer.sv
// Registered index with load and cyclic up/down stepping, decoded to one-hot.
// Define ONEHOT_SEQ_ERR_EN to add the sticky out-of-range load flag (err).
module onehot_sequencer #(
  parameter int N    = 4,
  parameter int OUTS = 16
) (
  input logic               clk,
  input logic               rst,
  onehot_sequencer_if.slave bus
);
  localparam logic [N-1:0] LAST     = N'(OUTS - 1);
  localparam logic [N:0]   OUTS_EXT = (N+1)'(OUTS);

  logic [N-1:0]    idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic            in_range;
  logic [OUTS-1:0] y_dec;
`ifdef ONEHOT_SEQ_ERR_EN
  logic            err_q, err_d;
`endif

  // Extra bit so the compare also works when OUTS == 2**N.
  assign in_range = ({1'b0, bus.w} < OUTS_EXT);

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
`ifdef ONEHOT_SEQ_ERR_EN
    err_d   = err_q;
`endif
    if (bus.clr) begin
      valid_d = 1'b0;
    end else if (bus.ld) begin
      if (in_range) begin
        idx_d   = bus.w;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
`ifdef ONEHOT_SEQ_ERR_EN
        err_d   = 1'b1;
`endif
      end
    end else if (bus.scan && valid_q) begin
      if (!bus.dir) begin
        if (idx_q == LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q + N'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = LAST;
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q - N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef ONEHOT_SEQ_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
`ifdef ONEHOT_SEQ_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // en gates only the decode, never the state.
  always_comb begin
    y_dec = '0;
    for (int i = 0; i < OUTS; i++) begin
      y_dec[i] = bus.en && valid_q && (idx_q == N'(i));
    end
  end

  assign bus.y     = y_dec;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
`ifdef ONEHOT_SEQ_ERR_EN
  assign bus.err   = err_q;
`endif
endmodule

// File: tb/tb_onehot_sequencer.sv
// Directed bench for onehot_sequencer: a default 16-output instance and a
// 10-output instance for out-of-range loads (err checked when ONEHOT_SEQ_ERR_EN).
module tb_onehot_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onehot_sequencer_if #(.N(4), .OUTS(16)) b16 ();
  onehot_sequencer_if #(.N(4), .OUTS(10)) b10 ();

  onehot_sequencer #(.N(4), .OUTS(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  onehot_sequencer #(.N(4), .OUTS(10)) dut10 (.clk(clk), .rst(rst), .bus(b10));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one command onto the selected instance (other one idles), then
  // advance one rising edge and settle 1ns past it.
  task automatic applyStimulus(input bit to10, input logic c, input logic l,
                               input logic [3:0] wv, input logic s,
                               input logic d, input logic e);
    if (to10) begin
      b10.clr = c; b10.ld = l; b10.w = wv; b10.scan = s; b10.dir = d; b10.en = e;
      b16.clr = 1'b0; b16.ld = 1'b0; b16.scan = 1'b0;
    end else begin
      b16.clr = c; b16.ld = l; b16.w = wv; b16.scan = s; b16.dir = d; b16.en = e;
      b10.clr = 1'b0; b10.ld = 1'b0; b10.scan = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp16;
  logic [3:0]  up_idx[4]  = '{4'd15, 4'd0, 4'd1, 4'd2};
  logic        up_wrap[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0]  dn_idx[3]  = '{4'd0, 4'd15, 4'd14};
  logic        dn_wrap[3] = '{1'b0, 1'b1, 1'b0};
  int          wraps;

  initial begin
    rst = 1'b1;
    b16.clr = 0; b16.ld = 0; b16.w = 0; b16.scan = 0; b16.dir = 0; b16.en = 1;
    b10.clr = 0; b10.ld = 0; b10.w = 0; b10.scan = 0; b10.dir = 0; b10.en = 1;
    #2;
    checkOutput("rst_y", 32'(b16.y), 32'h0);
    checkOutput("rst_idx", 32'(b16.idx), 32'h0);
    checkOutput("rst_valid", 32'(b16.valid), 32'h0);
    checkOutput("rst_wrap", 32'(b16.wrap), 32'h0);
    checkOutput("rst_y10", 32'(b10.y), 32'h0);
`ifdef ONEHOT_SEQ_ERR_EN
    checkOutput("rst_err", 32'(b10.err), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 1, 4'd5, 0, 0, 1);
    checkOutput("ld5_y", 32'(b16.y), 32'h0020);
    checkOutput("ld5_idx", 32'(b16.idx), 32'd5);
    checkOutput("ld5_valid", 32'(b16.valid), 32'd1);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 4'(i), 0, 0, 1);
      exp16 = 16'd1 << i;
      checkOutput("dec_y", 32'(b16.y), 32'(exp16));
    end

    // clr keeps idx; scan while deselected does nothing
    applyStimulus(0, 1, 0, 4'd0, 0, 0, 1);
    checkOutput("clr_valid", 32'(b16.valid), 32'd0);
    checkOutput("clr_idx", 32'(b16.idx), 32'd15);
    checkOutput("clr_y", 32'(b16.y), 32'h0);
    applyStimulus(0, 0, 0, 4'd0, 1, 0, 1);
    checkOutput("dsel_scan_idx", 32'(b16.idx), 32'd15);
    checkOutput("dsel_scan_valid", 32'(b16.valid), 32'd0);
    checkOutput("dsel_scan_wrap", 32'(b16.wrap), 32'd0);

    applyStimulus(0, 0, 1, 4'd14, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'd0, 1, 0, 1);
      checkOutput("up_idx", 32'(b16.idx), 32'(up_idx[i]));
      checkOutput("up_wrap", 32'(b16.wrap), 32'(up_wrap[i]));
    end
    checkOutput("up_y", 32'(b16.y), 32'h0004);

    applyStimulus(0, 0, 1, 4'd1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 4'd0, 1, 1, 1);
      checkOutput("dn_idx", 32'(b16.idx), 32'(dn_idx[i]));
      checkOutput("dn_wrap", 32'(b16.wrap), 32'(dn_wrap[i]));
    end

    // priorities: clr over ld, ld over scan
    applyStimulus(0, 1, 1, 4'd3, 1, 0, 1);
    checkOutput("clr_ld_valid", 32'(b16.valid), 32'd0);
    checkOutput("clr_ld_idx", 32'(b16.idx), 32'd14);
    applyStimulus(0, 0, 1, 4'd3, 1, 0, 1);
    checkOutput("ld_scan_idx", 32'(b16.idx), 32'd3);
    checkOutput("ld_scan_y", 32'(b16.y), 32'h0008);

    applyStimulus(0, 0, 0, 4'd0, 1, 0, 1);
    checkOutput("dirchg_up", 32'(b16.idx), 32'd4);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 1);
    checkOutput("dirchg_dn1", 32'(b16.idx), 32'd3);
    applyStimulus(0, 0, 0, 4'd0, 1, 1, 1);
    checkOutput("dirchg_dn2", 32'(b16.idx), 32'd2);

    // 32 continuous up-steps from 0: two wraps, back at 0
    applyStimulus(0, 0, 1, 4'd0, 0, 0, 1);
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 4'd0, 1, 0, 1);
      if (b16.wrap) wraps++;
    end
    checkOutput("wrap_count", 32'(wraps), 32'd2);
    checkOutput("wrap_end_idx", 32'(b16.idx), 32'd0);

    // blanking while scanning, then async reset between edges
    applyStimulus(0, 0, 1, 4'd7, 0, 0, 1);
    checkOutput("ld7_y", 32'(b16.y), 32'h0080);
    applyStimulus(0, 0, 0, 4'd0, 1, 0, 0);
    checkOutput("blank_y1", 32'(b16.y), 32'h0);
    checkOutput("blank_idx1", 32'(b16.idx), 32'd8);
    applyStimulus(0, 0, 0, 4'd0, 1, 0, 0);
    checkOutput("blank_y2", 32'(b16.y), 32'h0);
    checkOutput("blank_idx2", 32'(b16.idx), 32'd9);
    b16.en = 1'b1;
    #1;
    checkOutput("en_comb_y", 32'(b16.y), 32'h0200);
    rst = 1'b1;
    #1;
    checkOutput("arst_y", 32'(b16.y), 32'h0);
    checkOutput("arst_idx", 32'(b16.idx), 32'h0);
    checkOutput("arst_valid", 32'(b16.valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 1, 4'd2, 0, 0, 1);
    checkOutput("post_rst_y", 32'(b16.y), 32'h0004);

    // OUTS=10 instance: boundary wraps and out-of-range loads
    applyStimulus(1, 0, 1, 4'd9, 0, 0, 1);
    checkOutput("o10_ld9_y", 32'(b10.y), 32'h200);
    applyStimulus(1, 0, 0, 4'd0, 1, 0, 1);
    checkOutput("o10_upwrap_idx", 32'(b10.idx), 32'd0);
    checkOutput("o10_upwrap", 32'(b10.wrap), 32'd1);
    applyStimulus(1, 0, 0, 4'd0, 1, 1, 1);
    checkOutput("o10_dnwrap_idx", 32'(b10.idx), 32'd9);
    checkOutput("o10_dnwrap", 32'(b10.wrap), 32'd1);
    applyStimulus(1, 0, 1, 4'd12, 0, 0, 1);
    checkOutput("o10_oor_valid", 32'(b10.valid), 32'd0);
    checkOutput("o10_oor_y", 32'(b10.y), 32'h0);
    checkOutput("o10_oor_idx", 32'(b10.idx), 32'd9);
`ifdef ONEHOT_SEQ_ERR_EN
    checkOutput("o10_err_set", 32'(b10.err), 32'd1);
`endif
    applyStimulus(1, 1, 0, 4'd0, 0, 0, 1);
`ifdef ONEHOT_SEQ_ERR_EN
    checkOutput("o10_err_sticky", 32'(b10.err), 32'd1);
`endif
    applyStimulus(1, 0, 1, 4'd3, 1, 0, 1);
    checkOutput("o10_ld_scan_idx", 32'(b10.idx), 32'd3);
    checkOutput("o10_ld_scan_y", 32'(b10.y), 32'h008);
    applyStimulus(1, 0, 1, 4'd10, 0, 0, 1);
    checkOutput("o10_ld10_valid", 32'(b10.valid), 32'd0);
    checkOutput("o10_ld10_idx", 32'(b10.idx), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Parametrised, registered successor to the 4-to-16 one-hot decoder. It holds a selected index in a register and drives a one-hot output vector of configurable width. The index can be loaded directly, or stepped up or down cyclically with wrap-around, which makes the block usable as an address decoder or as a ring-style strobe/scan generator. It feeds row/enable strobes to downstream register files and display-scan logic.

## Interface
Parameters:
- `N`, default 4: select width in bits.
- `OUTS`, default 16: number of one-hot outputs. Legal range is 2 ≤ `OUTS` ≤ 2**`N`.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `clr`, input, 1: synchronous deselect. Sets valid to 0; the index is unchanged.
- `ld`, input, 1: load `w` into the index register.
- `w`, input, `N`: index to load.
- `scan`, input, 1: step the index by one each cycle while asserted.
- `dir`, input, 1: step direction. 0 = up (increment), 1 = down (decrement).
- `en`, input, 1: output enable. Combinational gate on `y` only; state is unaffected.
- `y`, output, `OUTS`: one-hot output vector.
- `idx`, output, `N`: current index register.
- `valid`, output, 1: index register holds a legal selection.
- `wrap`, output, 1: registered one-cycle pulse on every cyclic wrap.
- `err`, output, 1: sticky out-of-range load flag. Present only when `ONEHOT_SEQ_ERR_EN` is defined.

## Operation
- Registered state: `idx`, `valid`, `wrap`, and `err` (macro only).
- Output decode:
  - `y[i] = en && valid && (idx == i)`.
  - At most one bit of `y` is ever set.
  - `y` is all zeros when `en` = 0 or `valid` = 0.
- Per-edge priority: `clr` > `ld` > `scan`. Only the highest-priority active command takes effect.
- `clr`:
  - `valid` ← 0, `wrap` ← 0.
  - `idx` keeps its value.
- `ld` with `w` < `OUTS`: `idx` ← `w`, `valid` ← 1, `wrap` ← 0.
- `ld` with `w` ≥ `OUTS` (possible only when `OUTS` < 2**`N`):
  - `valid` ← 0, `idx` keeps its value, `wrap` ← 0.
  - `err` ← 1 (macro only).
- `scan` with `valid` = 1 and `dir` = 0:
  - `idx` == `OUTS`−1 → `idx` ← 0, `wrap` ← 1.
  - Otherwise `idx` ← `idx`+1, `wrap` ← 0.
- `scan` with `valid` = 1 and `dir` = 1:
  - `idx` == 0 → `idx` ← `OUTS`−1, `wrap` ← 1.
  - Otherwise `idx` ← `idx`−1, `wrap` ← 0.
- `scan` with `valid` = 0: no step, `wrap` ← 0. A deselected sequencer stays deselected.
- No command active: hold `idx` and `valid`, `wrap` ← 0.
- Arithmetic:
  - Index arithmetic is `N` bits wide.
  - Wrap is compared against `OUTS`−1, not against 2**`N`−1. Out-of-range index values are never reached by stepping.
- `en` never affects state. Scanning continues while the outputs are blanked.

## Timing
- Reset values (asynchronous, immediate on `rst` high): `idx` = 0, `valid` = 0, `wrap` = 0, `err` = 0, `y` = all zeros.
- Reset asserted mid-scan aborts the scan immediately. After release, the first edge with `ld` or `scan` applies normally.
- Latency:
  - Command sampled at edge k → `idx`/`valid`/`wrap` updated after edge k → `y` valid in the same cycle (zero-cycle decode from registers).
  - `en` → `y` is purely combinational, with zero latency.
- `wrap` is high for exactly the one cycle following the wrapping edge.
  - Continuous scan with `OUTS` = 16 gives one `wrap` every 16 cycles.
- `ld` and `scan` in the same cycle: load wins. The loaded value is not stepped in that cycle.
- Changing `dir` mid-scan takes effect at the next edge. No bubble is inserted.

## Configuration
- `ONEHOT_SEQ_ERR_EN` defined:
  - `err` port and register exist.
  - `err` sets on any out-of-range load and clears only on `rst`. `clr` does not clear it.
- `ONEHOT_SEQ_ERR_EN` undefined:
  - No `err` port or register.
  - Out-of-range loads still force `valid` = 0.

## Test plan
- Reset then release, defaults N=4/OUTS=16, `en`=1 → `y`=0, `idx`=0, `valid`=0. Then `ld` `w`=5 → `y`=16'h0020 on the next cycle.
- Load all 16 values 0..15 in turn → `y` = 1<<`w` each cycle, matching the 4-to-16 decode exactly.
- Load 14, `scan`=1, `dir`=0 for 4 cycles → `idx` sequence 15, 0, 1, 2. `wrap` high only in the cycle where `idx`=0.
- Load 1, `scan`=1, `dir`=1 for 3 cycles → `idx` sequence 0, 15, 14. One `wrap` pulse, in the cycle where `idx`=15.
- N=4, OUTS=10, macro on: `ld` `w`=12 → `valid`=0, `y`=0, `err`=1. Then `clr` → `err` stays 1. Then `ld` `w`=3 with `scan`=1 in the same cycle → `idx`=3 (load wins), `y`=10'h008.
- Mid-scan at `idx`=7: `en`=0 for 2 cycles → `y`=0 while `idx` advances to 9. Then assert `rst` asynchronously between edges → all outputs 0 immediately.
